// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller for a latch-based clock-gating cell.
// Gates the downstream clock after a programmable idle period, services a
// sleep request/acknowledge handshake, and delays clk_rdy after wake-up.
// Runs on the ungated forever clock upstream of the gate it controls.
module clk_gate_ctrl #(
   parameter int unsigned IDLE_CNT_W = 4,
   parameter int unsigned WAKE_CYC   = 2,
   parameter int unsigned STAT_W     = 16
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  gate_en,
   input  logic [IDLE_CNT_W-1:0] idle_thresh,
   input  logic                  module_busy,
   input  logic                  wake_req,
   input  logic                  sleep_req,
   output logic                  sleep_ack,
   input  logic                  pad_yy_icg_scan_en,
   output logic                  clk_en,
   output logic                  clk_rdy,
   output logic                  gate_st,
   input  logic                  stat_clr,
   output logic [STAT_W-1:0]     gate_cyc_cnt
);

   typedef enum logic [1:0] {StRun, StIdleWait, StGated, StWake} state_e;

   // Last wake_cnt value before clk_rdy is released.
   localparam logic [3:0] WakeLast = 4'(WAKE_CYC - 1);

   state_e                  state_q, state_d;
   logic                    clk_en_q, clk_en_d;
   logic                    clk_rdy_q, clk_rdy_d;
   logic                    sleep_ack_q, sleep_ack_d;
   logic                    gate_st_q, gate_st_d;
   logic                    sleep_mode_q, sleep_mode_d;
   logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [3:0]              wake_cnt_q, wake_cnt_d;
   logic [STAT_W-1:0]       stat_q, stat_d;
   logic                    gated_exit;

   // Next-state and registered-output decode.
   always_comb begin
      state_d      = state_q;
      clk_en_d     = clk_en_q;
      clk_rdy_d    = clk_rdy_q;
      sleep_ack_d  = sleep_ack_q;
      gate_st_d    = gate_st_q;
      sleep_mode_d = sleep_mode_q;
      idle_cnt_d   = idle_cnt_q;
      wake_cnt_d   = wake_cnt_q;
      gated_exit   = 1'b0;

      unique case (state_q)
         StRun: begin
            // Busy wins over a simultaneous sleep request.
            if (sleep_req && !module_busy) begin
               state_d      = StGated;
               sleep_mode_d = 1'b1;
               clk_en_d     = 1'b0;
               clk_rdy_d    = 1'b0;
               gate_st_d    = 1'b1;
            end else if (gate_en && !module_busy) begin
               state_d    = StIdleWait;
               idle_cnt_d = '0;
            end
         end
         StIdleWait: begin
            if (module_busy || wake_req || !gate_en) begin
               state_d = StRun;
            end else if (sleep_req || (idle_cnt_q == idle_thresh)) begin
               state_d      = StGated;
               sleep_mode_d = sleep_req;
               clk_en_d     = 1'b0;
               clk_rdy_d    = 1'b0;
               gate_st_d    = 1'b1;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         StGated: begin
            // In sleep mode only the power manager (or an explicit wake) releases us;
            // an idle gate also yields to a new sleep request.
            if (sleep_mode_q) begin
               gated_exit = !sleep_req || wake_req;
            end else begin
               gated_exit = !sleep_req && (module_busy || wake_req || !gate_en);
            end
            if (gated_exit) begin
               state_d      = StWake;
               clk_en_d     = 1'b1;
               sleep_ack_d  = 1'b0;
               wake_cnt_d   = '0;
               sleep_mode_d = 1'b0;
               gate_st_d    = 1'b0;
            end else begin
               if (sleep_req) begin
                  sleep_mode_d = 1'b1;
               end
               sleep_ack_d = sleep_mode_d && sleep_req;
            end
         end
         StWake: begin
            if (wake_cnt_q == WakeLast) begin
               state_d   = StRun;
               clk_rdy_d = 1'b1;
            end else begin
               wake_cnt_d = wake_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q      <= StRun;
         clk_en_q     <= 1'b1;
         clk_rdy_q    <= 1'b1;
         sleep_ack_q  <= 1'b0;
         gate_st_q    <= 1'b0;
         sleep_mode_q <= 1'b0;
         idle_cnt_q   <= '0;
         wake_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         clk_en_q     <= clk_en_d;
         clk_rdy_q    <= clk_rdy_d;
         sleep_ack_q  <= sleep_ack_d;
         gate_st_q    <= gate_st_d;
         sleep_mode_q <= sleep_mode_d;
         idle_cnt_q   <= idle_cnt_d;
         wake_cnt_q   <= wake_cnt_d;
      end
   end

   // Saturating gated-cycle statistic; clear beats increment.
   always_comb begin
      stat_d = stat_q;
      if (stat_clr) begin
         stat_d = '0;
      end else if (gate_st_q && !(&stat_q)) begin
         stat_d = stat_q + 1'b1;
      end
   end

   // Statistic register.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   // Scan mode must never leave the gate closed.
   assign clk_en       = clk_en_q | pad_yy_icg_scan_en;
   assign clk_rdy      = clk_rdy_q;
   assign sleep_ack    = sleep_ack_q;
   assign gate_st      = gate_st_q;
   assign gate_cyc_cnt = stat_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed testbench for clk_gate_ctrl with hand-computed expectations.
module tb_clk_gate_ctrl;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        gate_en, module_busy, wake_req, sleep_req, scan_en, stat_clr;
   logic [3:0]  idle_thresh;
   logic        sleep_ack, clk_en, clk_rdy, gate_st;
   logic [15:0] gate_cyc_cnt;

   int tests_run = 0;
   int fails = 0;

   always #5 clk = ~clk;

   clk_gate_ctrl #(
      .IDLE_CNT_W (4),
      .WAKE_CYC   (2),
      .STAT_W     (16)
   ) dut (
      .forever_cpuclk     (clk),
      .cpurst_b           (rst_b),
      .gate_en            (gate_en),
      .idle_thresh        (idle_thresh),
      .module_busy        (module_busy),
      .wake_req           (wake_req),
      .sleep_req          (sleep_req),
      .sleep_ack          (sleep_ack),
      .pad_yy_icg_scan_en (scan_en),
      .clk_en             (clk_en),
      .clk_rdy            (clk_rdy),
      .gate_st            (gate_st),
      .stat_clr           (stat_clr),
      .gate_cyc_cnt       (gate_cyc_cnt)
   );

   // Advance n clock edges; sample and drive 1ns after the edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Output vector: {clk_en, clk_rdy, sleep_ack, gate_st}.
   task automatic test_reset();
      rst_b = 1'b0; gate_en = 1'b0; module_busy = 1'b1; wake_req = 1'b0;
      sleep_req = 1'b0; scan_en = 1'b0; stat_clr = 1'b0; idle_thresh = 4'd3;
      tick(3);
      rst_b = 1'b1;
      tick(2);
      tests_run++;
      if ({clk_en, clk_rdy, sleep_ack, gate_st} !== 4'b1100) begin
         fails++;
         $display("FAIL reset_outputs got %b want 1100", {clk_en, clk_rdy, sleep_ack, gate_st});
      end
      tests_run++;
      if (gate_cyc_cnt !== 16'd0) begin
         fails++; $display("FAIL reset_cnt got %0d want 0", gate_cyc_cnt);
      end
   endtask

   task automatic test_idle_gate();
      gate_en = 1'b1; idle_thresh = 4'd3; module_busy = 1'b0;
      tick(4);
      tests_run++;
      if (clk_en !== 1'b1) begin
         fails++; $display("FAIL idle_before_gate clk_en got %b want 1", clk_en);
      end
      tick(1);
      tests_run++;
      if ({clk_en, clk_rdy, sleep_ack, gate_st} !== 4'b0001) begin
         fails++;
         $display("FAIL idle_gated got %b want 0001", {clk_en, clk_rdy, sleep_ack, gate_st});
      end
      tick(4);
      module_busy = 1'b1;
      tick(1);
      tests_run++;
      if ({clk_en, clk_rdy, sleep_ack, gate_st} !== 4'b1000) begin
         fails++;
         $display("FAIL idle_wake got %b want 1000", {clk_en, clk_rdy, sleep_ack, gate_st});
      end
      tests_run++;
      if (gate_cyc_cnt !== 16'd5) begin
         fails++; $display("FAIL idle_stat got %0d want 5", gate_cyc_cnt);
      end
      tick(1);
      tests_run++;
      if (clk_rdy !== 1'b0) begin
         fails++; $display("FAIL wake_rdy_early got %b want 0", clk_rdy);
      end
      tick(1);
      tests_run++;
      if (clk_rdy !== 1'b1) begin
         fails++; $display("FAIL wake_rdy got %b want 1", clk_rdy);
      end
   endtask

   task automatic test_busy_restart();
      module_busy = 1'b0;
      tick(3);
      module_busy = 1'b1;
      tick(1);
      module_busy = 1'b0;
      tick(4);
      tests_run++;
      if ({clk_en, gate_st} !== 2'b10) begin
         fails++; $display("FAIL restart_not_gated got %b want 10", {clk_en, gate_st});
      end
      tick(1);
      tests_run++;
      if ({clk_en, gate_st} !== 2'b01) begin
         fails++; $display("FAIL restart_gated got %b want 01", {clk_en, gate_st});
      end
      gate_en = 1'b0;
      tick(1);
      tests_run++;
      if ({clk_en, gate_st} !== 2'b10) begin
         fails++; $display("FAIL gate_en_exit got %b want 10", {clk_en, gate_st});
      end
      tick(2);
   endtask

   task automatic test_sleep();
      module_busy = 1'b1; sleep_req = 1'b1;
      tick(1);
      tests_run++;
      if ({clk_en, gate_st} !== 2'b10) begin
         fails++; $display("FAIL busy_beats_sleep got %b want 10", {clk_en, gate_st});
      end
      module_busy = 1'b0;
      tick(1);
      tests_run++;
      if ({clk_en, clk_rdy, sleep_ack, gate_st} !== 4'b0001) begin
         fails++;
         $display("FAIL sleep_entry got %b want 0001", {clk_en, clk_rdy, sleep_ack, gate_st});
      end
      tick(1);
      tests_run++;
      if (sleep_ack !== 1'b1) begin
         fails++; $display("FAIL sleep_ack got %b want 1", sleep_ack);
      end
      module_busy = 1'b1;
      tick(1);
      module_busy = 1'b0;
      tests_run++;
      if ({clk_en, sleep_ack, gate_st} !== 3'b011) begin
         fails++; $display("FAIL sleep_busy_ignored got %b want 011", {clk_en, sleep_ack, gate_st});
      end
      sleep_req = 1'b0;
      tick(1);
      tests_run++;
      if ({clk_en, clk_rdy, sleep_ack, gate_st} !== 4'b1000) begin
         fails++;
         $display("FAIL sleep_exit got %b want 1000", {clk_en, clk_rdy, sleep_ack, gate_st});
      end
      tick(2);
      tests_run++;
      if (clk_rdy !== 1'b1) begin
         fails++; $display("FAIL sleep_rdy got %b want 1", clk_rdy);
      end
   endtask

   task automatic test_idle_then_sleep();
      module_busy = 1'b1; gate_en = 1'b1; idle_thresh = 4'd0;
      tick(1);
      module_busy = 1'b0;
      tick(1);
      tests_run++;
      if (clk_en !== 1'b1) begin
         fails++; $display("FAIL thresh0_wait clk_en got %b want 1", clk_en);
      end
      tick(1);
      tests_run++;
      if ({clk_en, sleep_ack, gate_st} !== 3'b001) begin
         fails++; $display("FAIL thresh0_gated got %b want 001", {clk_en, sleep_ack, gate_st});
      end
      sleep_req = 1'b1;
      tick(1);
      module_busy = 1'b1;
      tests_run++;
      if ({clk_en, sleep_ack, gate_st} !== 3'b011) begin
         fails++; $display("FAIL idle_to_sleep got %b want 011", {clk_en, sleep_ack, gate_st});
      end
      tick(1);
      tests_run++;
      if ({clk_en, gate_st} !== 2'b01) begin
         fails++; $display("FAIL idle_sleep_busy got %b want 01", {clk_en, gate_st});
      end
      wake_req = 1'b1;
      tick(1);
      wake_req = 1'b0; sleep_req = 1'b0; gate_en = 1'b0;
      tests_run++;
      if ({clk_en, clk_rdy, sleep_ack, gate_st} !== 4'b1000) begin
         fails++;
         $display("FAIL wake_req_exit got %b want 1000", {clk_en, clk_rdy, sleep_ack, gate_st});
      end
      tick(2);
   endtask

   task automatic test_saturate();
      module_busy = 1'b0; sleep_req = 1'b1;
      tick(1);
      stat_clr = 1'b1;
      tick(1);
      stat_clr = 1'b0;
      tests_run++;
      if (gate_cyc_cnt !== 16'd0) begin
         fails++; $display("FAIL stat_clr_start got %0d want 0", gate_cyc_cnt);
      end
      tick(1000);
      tests_run++;
      if (gate_cyc_cnt !== 16'd1000) begin
         fails++; $display("FAIL stat_mid got %0d want 1000", gate_cyc_cnt);
      end
      tick(69000);
      tests_run++;
      if (gate_cyc_cnt !== 16'hFFFF) begin
         fails++; $display("FAIL stat_sat got %h want ffff", gate_cyc_cnt);
      end
      stat_clr = 1'b1;
      tick(1);
      stat_clr = 1'b0;
      tests_run++;
      if (gate_cyc_cnt !== 16'd0) begin
         fails++; $display("FAIL stat_clr got %0d want 0", gate_cyc_cnt);
      end
      tick(1);
      tests_run++;
      if (gate_cyc_cnt !== 16'd1) begin
         fails++; $display("FAIL stat_restart got %0d want 1", gate_cyc_cnt);
      end
   endtask

   task automatic test_scan();
      scan_en = 1'b1;
      #1;
      tests_run++;
      if ({clk_en, gate_st} !== 2'b11) begin
         fails++; $display("FAIL scan_force got %b want 11", {clk_en, gate_st});
      end
      tick(1);
      tests_run++;
      if ({clk_en, sleep_ack, gate_st} !== 3'b111) begin
         fails++; $display("FAIL scan_hold got %b want 111", {clk_en, sleep_ack, gate_st});
      end
      scan_en = 1'b0;
      #1;
      tests_run++;
      if (clk_en !== 1'b0) begin
         fails++; $display("FAIL scan_release got %b want 0", clk_en);
      end
   endtask

   task automatic test_async_reset();
      // Still gated in sleep mode with sleep_ack high.
      rst_b = 1'b0;
      #1;
      tests_run++;
      if ({clk_en, clk_rdy, sleep_ack, gate_st} !== 4'b1100) begin
         fails++;
         $display("FAIL rst_gated got %b want 1100", {clk_en, clk_rdy, sleep_ack, gate_st});
      end
      tests_run++;
      if (gate_cyc_cnt !== 16'd0) begin
         fails++; $display("FAIL rst_cnt got %0d want 0", gate_cyc_cnt);
      end
      sleep_req = 1'b0;
      #1;
      rst_b = 1'b1;
      tick(1);
      sleep_req = 1'b1;
      tick(2);
      sleep_req = 1'b0;
      tick(1);
      tests_run++;
      if ({clk_en, clk_rdy, gate_st} !== 3'b100) begin
         fails++; $display("FAIL pre_rst_wake got %b want 100", {clk_en, clk_rdy, gate_st});
      end
      rst_b = 1'b0;
      #1;
      tests_run++;
      if ({clk_en, clk_rdy, sleep_ack, gate_st} !== 4'b1100) begin
         fails++;
         $display("FAIL rst_wake got %b want 1100", {clk_en, clk_rdy, sleep_ack, gate_st});
      end
      #1;
      rst_b = 1'b1;
      tick(2);
      tests_run++;
      if ({clk_en, clk_rdy, gate_st} !== 3'b110) begin
         fails++; $display("FAIL post_rst_run got %b want 110", {clk_en, clk_rdy, gate_st});
      end
   endtask

   initial begin
      test_reset();
      test_idle_gate();
      test_busy_restart();
      test_sleep();
      test_idle_then_sleep();
      test_saturate();
      test_scan();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Generates the clock-enable (CE) that feeds a latch-based clock-gating cell.
- Watches a module's busy indication. After a programmable idle period it drops CE. It also services a sleep request/acknowledge handshake from the power manager.
- On wake it re-enables the clock and holds off a ready indication for a fixed settle time.
- Runs on the ungated forever clock that sits upstream of the gate it controls.

Parameters:
- IDLE_CNT_W, 4: width of the idle threshold and idle counter.
- WAKE_CYC, 2: cycles from CE re-assertion to clk_rdy assertion; range 1..15.
- STAT_W, 16: width of the saturating gated-cycle statistic counter.

Ports:
- forever_cpuclk  in  1  ungated clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- gate_en  in  1  software enable for idle-based gating; 0 keeps the clock running.
- idle_thresh  in  IDLE_CNT_W  number of extra idle cycles required before gating.
- module_busy  in  1  the gated module has work pending.
- wake_req  in  1  external wake pulse/level.
- sleep_req  in  1  power-manager sleep request, level.
- sleep_ack  out  1  sleep granted; the clock is gated.
- pad_yy_icg_scan_en  in  1  scan mode; forces CE high.
- clk_en  out  1  CE to the gating cell.
- clk_rdy  out  1  the gated clock is stable and usable.
- gate_st  out  1  the controller is in the GATED state.
- stat_clr  in  1  synchronous clear of gate_cyc_cnt.
- gate_cyc_cnt  out  STAT_W  count of cycles spent in GATED, saturating.

Behaviour:
- States: RUN, IDLE_WAIT, GATED, WAKE. All state, counters and outputs are registered.
- The only combinational output path is clk_en = clk_en_q | pad_yy_icg_scan_en.
- Reset values: state RUN; clk_en_q 1; clk_rdy 1; sleep_ack 0; gate_st 0; idle_cnt 0; wake_cnt 0; sleep_mode 0; gate_cyc_cnt 0. Asserting reset in any state returns to these values immediately.
- RUN (clk_en_q=1, clk_rdy=1), evaluated in priority order:
  - sleep_req & !module_busy -> GATED, sleep_mode=1.
  - else gate_en & !module_busy -> IDLE_WAIT, idle_cnt=0.
- IDLE_WAIT (clk_en_q=1), evaluated in priority order:
  - module_busy | wake_req | !gate_en -> RUN.
  - sleep_req -> GATED, sleep_mode=1.
  - idle_cnt==idle_thresh -> GATED, sleep_mode=0.
  - else idle_cnt++.
  - Net effect: with gate_en=1, busy low from cycle N makes clk_en_q fall at the edge ending cycle N+idle_thresh+1. idle_thresh=0 gates after 1 idle cycle in IDLE_WAIT.
- GATED (clk_en_q=0, gate_st=1, clk_rdy=0):
  - sleep_ack = sleep_mode & sleep_req, registered, so it rises one cycle after entry.
  - A sleep_req that rises while idle-gated sets sleep_mode=1 and the controller stays gated.
  - Exit -> WAKE when:
    - sleep_mode=1: !sleep_req | wake_req. module_busy is ignored.
    - sleep_mode=0: module_busy | wake_req | !gate_en (when sleep_req=0).
  - On exit: clk_en_q=1, sleep_ack=0, wake_cnt=0, sleep_mode=0, gate_st=0.
- WAKE (clk_en_q=1, clk_rdy=0):
  - wake_cnt increments each cycle; when wake_cnt==WAKE_CYC-1 -> RUN with clk_rdy=1.
  - All inputs are ignored here; a pending sleep_req is re-evaluated in RUN.
  - clk_rdy therefore rises exactly WAKE_CYC cycles after clk_en_q rises.
- gate_cyc_cnt:
  - Increments every cycle gate_st=1.
  - Saturates at all-ones.
  - stat_clr has priority over increment; the counter reads 0 on the next cycle.
- Scan: pad_yy_icg_scan_en=1 forces clk_en=1 regardless of state. The FSM keeps running and the status outputs are unaffected.
- Simultaneous sleep_req and module_busy in RUN: busy wins and the controller stays in RUN.

Test Plan:
- Reset; gate_en=1, idle_thresh=3; busy 1->0 at cycle 10 -> IDLE_WAIT at 11; clk_en=0 and gate_st=1 from cycle 15. Then busy=1 at cycle 20 -> clk_en=1 at 21, clk_rdy=1 at 23 (WAKE_CYC=2).
- idle_thresh=3; busy pulses high for 1 cycle while idle_cnt=2 -> returns to RUN and the count restarts; gating occurs only after 4 consecutive idle cycles.
- gate_en=0, busy=0, sleep_req=1 -> GATED next cycle, sleep_ack=1 the cycle after. A busy pulse leaves it gated; sleep_req=0 -> sleep_ack=0, clk_en=1 next cycle, clk_rdy WAKE_CYC later.
- Gated for 70000 cycles with STAT_W=16 -> gate_cyc_cnt=16'hFFFF and holds. Pulse stat_clr -> 0 next cycle.
- pad_yy_icg_scan_en=1 while GATED -> clk_en=1 immediately, gate_st stays 1. Deassert -> clk_en=0.
- Drop cpurst_b mid-WAKE and mid-GATED -> clk_en=1, clk_rdy=1, sleep_ack=0, gate_st=0 asynchronously.
